// File: rtl/alu_defs_pkg.sv
// alu_defs_pkg
// Shared definitions for the execute-stage ALU.
// It holds the 4-bit operation codes that the ALU control decoder also uses,
// the FSM state encoding, and the default operand and shift-amount widths.
// The optional macro ALU_BARREL_SHIFT_EN does not change anything in this file.
package alu_defs_pkg;

  localparam int ALU_DATA_WIDTH  = 32;
  localparam int ALU_SHAMT_WIDTH = 5;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_SRL = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_LUI = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_SLL = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SRL) || (op == OP_SLL);
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_if
// This interface carries the request and result handshake of the ALU execute unit.
//   ALU_Operation_i, A_i, B_i, valid_i : request from the operand muxes
//   ready_o                            : the unit can accept a request
//   result_o, zero_o, valid_o          : result going to the write-back mux
//   ready_i                            : write-back accepts the result
// Modports:
//   slave  : the execute unit
//   master : the upstream and downstream logic, or the testbench
// The optional macro ALU_BARREL_SHIFT_EN does not change this interface.
interface alu_exec_if #(
  parameter int DATA_WIDTH = 32
);
  logic [3:0]            ALU_Operation_i;
  logic [DATA_WIDTH-1:0] A_i;
  logic [DATA_WIDTH-1:0] B_i;
  logic                  valid_i;
  logic                  ready_o;
  logic [DATA_WIDTH-1:0] result_o;
  logic                  zero_o;
  logic                  valid_o;
  logic                  ready_i;

  modport slave (
    input  ALU_Operation_i, A_i, B_i, valid_i, ready_i,
    output ready_o, result_o, zero_o, valid_o
  );

  modport master (
    output ALU_Operation_i, A_i, B_i, valid_i, ready_i,
    input  ready_o, result_o, zero_o, valid_o
  );
endinterface

// File: rtl/alu_shift_unit.sv
// alu_shift_unit
// This module is the shifter of the ALU execute unit.
// When ALU_BARREL_SHIFT_EN is undefined (the default build):
//   - a shift register and a down-counter are loaded on i_load;
//   - the value moves one bit per i_step, with zero fill;
//   - o_result is the value after the shift that is pending;
//   - o_last is high when that pending shift is the final one.
// When ALU_BARREL_SHIFT_EN is defined:
//   - a combinational barrel shift of i_a by i_shamt is built;
//   - o_last is tied high.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   i_load     : capture i_a, i_shamt and i_left
//   i_step     : perform one single-bit shift
//   i_left     : 1 = SLL, 0 = SRL
//   i_a        : value to shift
//   i_shamt    : shift amount
//   o_result   : shift result (see above)
//   o_last     : the current step finishes the shift
module alu_shift_unit
  import alu_defs_pkg::*;
#(
  parameter int DATA_WIDTH  = ALU_DATA_WIDTH,
  parameter int SHAMT_WIDTH = ALU_SHAMT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_load,
  input  logic                   i_step,
  input  logic                   i_left,
  input  logic [DATA_WIDTH-1:0]  i_a,
  input  logic [SHAMT_WIDTH-1:0] i_shamt,
  output logic [DATA_WIDTH-1:0]  o_result,
  output logic                   o_last
);

`ifdef ALU_BARREL_SHIFT_EN

  logic w_unused;
  assign w_unused = ^{clk, reset, i_load, i_step};

  assign o_result = i_left ? (i_a << i_shamt) : (i_a >> i_shamt);
  assign o_last   = 1'b1;

`else

  logic [DATA_WIDTH-1:0]  r_shreg;
  logic [SHAMT_WIDTH-1:0] r_cnt;
  logic                   r_left;
  logic [DATA_WIDTH-1:0]  w_next;

  assign w_next = r_left ? {r_shreg[DATA_WIDTH-2:0], 1'b0}
                         : {1'b0, r_shreg[DATA_WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_left  <= 1'b0;
    end else if (i_load) begin
      r_shreg <= i_a;
      r_cnt   <= i_shamt;
      r_left  <= i_left;
    end else if (i_step) begin
      r_shreg <= w_next;
      r_cnt   <= r_cnt - 1'b1;
    end
  end

  // The step taken while the counter reads 1 is the last one, so the
  // top captures w_next directly instead of waiting a further cycle.
  assign o_result = w_next;
  assign o_last   = (r_cnt == SHAMT_WIDTH'(1));

`endif

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// This is the multi-cycle ALU for the execute stage.
//   - Single-cycle ops (ADD, SUB, AND, XOR, LUI, OR, undefined codes) are
//     registered in one cycle. Undefined codes give a result of 0.
//   - SLL and SRL use alu_shift_unit.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : alu_exec_if.slave, which carries the request and result handshake
// Macro ALU_BARREL_SHIFT_EN:
//   - defined: shifts complete in one cycle and ST_SHIFT is never entered;
//   - undefined (default): the shift moves one bit per cycle.
//
// state    | meaning
// ST_IDLE  | ready_o high, waiting for valid_i
// ST_SHIFT | iterative shift in progress, one bit per cycle
// ST_DONE  | valid_o high, result held until ready_i
module alu_exec_unit
  import alu_defs_pkg::*;
#(
  parameter int DATA_WIDTH  = ALU_DATA_WIDTH,
  parameter int SHAMT_WIDTH = ALU_SHAMT_WIDTH
) (
  input  logic   clk,
  input  logic   reset,
  alu_exec_if.slave bus
);

  alu_state_e            r_state;
  alu_state_e            w_next_state;
  logic [DATA_WIDTH-1:0] r_result;

  logic                  w_cap_comb;
  logic                  w_cap_pass;
  logic                  w_cap_shift;
  logic                  w_load;
  logic                  w_step;
  logic                  w_is_shift;
  logic [DATA_WIDTH-1:0] w_comb_result;
  logic [DATA_WIDTH-1:0] w_shift_result;
  logic                  w_shift_last;
  logic [SHAMT_WIDTH-1:0] w_shamt;

  assign w_shamt    = bus.B_i[SHAMT_WIDTH-1:0];
  assign w_is_shift = is_shift_op(bus.ALU_Operation_i);

  alu_shift_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHAMT_WIDTH(SHAMT_WIDTH)
  ) u_shift (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_left  (bus.ALU_Operation_i == OP_SLL),
    .i_a     (bus.A_i),
    .i_shamt (w_shamt),
    .o_result(w_shift_result),
    .o_last  (w_shift_last)
  );

  always_comb begin
    w_comb_result = '0;
    case (bus.ALU_Operation_i)
      OP_ADD:  w_comb_result = bus.A_i + bus.B_i;
      OP_SUB:  w_comb_result = bus.A_i - bus.B_i;
      OP_AND:  w_comb_result = bus.A_i & bus.B_i;
      OP_XOR:  w_comb_result = bus.A_i ^ bus.B_i;
      OP_LUI:  w_comb_result = bus.B_i;
      OP_OR:   w_comb_result = bus.A_i | bus.B_i;
      default: w_comb_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_cap_comb   = 1'b0;
    w_cap_pass   = 1'b0;
    w_cap_shift  = 1'b0;
    w_load       = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.valid_i) begin
          w_next_state = ST_DONE;
          if (!w_is_shift) begin
            w_cap_comb = 1'b1;
          end else begin
`ifdef ALU_BARREL_SHIFT_EN
            w_cap_shift = 1'b1;
`else
            if (w_shamt == '0) begin
              w_cap_pass = 1'b1;
            end else begin
              w_load       = 1'b1;
              w_next_state = ST_SHIFT;
            end
`endif
          end
        end
      end
      ST_SHIFT: begin
        w_step = 1'b1;
        if (w_shift_last) begin
          w_cap_shift  = 1'b1;
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.ready_i) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)            r_result <= '0;
    else if (w_cap_comb)  r_result <= w_comb_result;
    else if (w_cap_pass)  r_result <= bus.A_i;
    else if (w_cap_shift) r_result <= w_shift_result;
  end

  // Combining with reset keeps ready_o low during the reset cycle itself.
  assign bus.ready_o  = (r_state == ST_IDLE) && !reset;
  assign bus.valid_o  = (r_state == ST_DONE);
  assign bus.result_o = r_result;
  assign bus.zero_o   = (r_state == ST_DONE) && (r_result == '0);

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
  import alu_defs_pkg::*;

`ifdef ALU_BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_exec_if #(.DATA_WIDTH(32)) bus ();

  alu_exec_unit dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Behavioural reference model, written directly from the op-code table.
  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int unsigned sh;
    logic [63:0] wide;
    sh = b % 32;
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a & b;
      4'b0011: return a / (32'd1 << sh);
      4'b0100: return a ^ b;
      4'b1000: return b;
      4'b1001: return a | b;
      4'b1100: begin
        wide = 64'(a) * (64'd1 << sh);
        return wide[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    if ((op == 4'b0011 || op == 4'b1100) && !BARREL && sh != 0) return int'(sh) + 1;
    return 1;
  endfunction

  // Issues one op, measures its latency, captures the result, and then
  // completes the output transfer. It finishes just after a falling edge.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic z, output int lat);
    int guard;
    guard = 0;
    while (!bus.ready_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("ready_wait", {31'b0, bus.ready_o}, 32'd1);
    bus.ALU_Operation_i = op;
    bus.A_i = a;
    bus.B_i = b;
    bus.valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    bus.A_i = $urandom;
    bus.B_i = $urandom;
    lat = 1;
    @(negedge clk);
    while (!bus.valid_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = bus.result_o;
    z   = bus.zero_o;
    bus.ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.ready_i = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] res;
    logic        z;
    int          lat;
    int          bad;
    logic [3:0]  codes[8];

    vecs.push_back('{"add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h1,        32'h0,         1'b1, 1});
    vecs.push_back('{"sub_neg",  4'b0001, 32'h5,         32'h7,        32'hFFFF_FFFE, 1'b0, 1});
    vecs.push_back('{"srl_31",   4'b0011, 32'h8000_0000, 32'd31,       32'h1,         1'b0, BARREL ? 1 : 32});
    vecs.push_back('{"sll_0",    4'b1100, 32'h3,         32'h0,        32'h3,         1'b0, 1});
    vecs.push_back('{"lui",      4'b1000, 32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000, 1'b0, 1});
    vecs.push_back('{"undef_f",  4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0,        1'b1, 1});
    vecs.push_back('{"and",      4'b0010, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000, 1'b0, 1});
    vecs.push_back('{"xor_self", 4'b0100, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0,        1'b1, 1});
    vecs.push_back('{"sll_31",   4'b1100, 32'h1,         32'd31,       32'h8000_0000, 1'b0, BARREL ? 1 : 32});
    vecs.push_back('{"srl_hi_b", 4'b0011, 32'h8,         32'hFFFF_FFE1, 32'h4,        1'b0, BARREL ? 1 : 2});
    vecs.push_back('{"sll_4",    4'b1100, 32'hF000_000F, 32'd4,        32'h0000_00F0, 1'b0, BARREL ? 1 : 5});
    vecs.push_back('{"undef_5",  4'b0101, 32'h1,         32'h1,        32'h0,         1'b1, 1});

    reset = 1'b1;
    bus.ALU_Operation_i = 4'b0;
    bus.A_i = '0;
    bus.B_i = '0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready",  {31'b0, bus.ready_o}, 32'd0);
    check("rst_valid",  {31'b0, bus.valid_o}, 32'd0);
    check("rst_result", bus.result_o, 32'd0);
    check("rst_zero",   {31'b0, bus.zero_o}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'b0, bus.ready_o}, 32'd1);

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, z, lat);
      check({vecs[i].name, "_result"},  res, vecs[i].res);
      check({vecs[i].name, "_zero"},    {31'b0, z}, {31'b0, vecs[i].z});
      check({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].lat));
      check({vecs[i].name, "_ready_after"}, {31'b0, bus.ready_o}, 32'd1);
      check({vecs[i].name, "_zero_unqual"}, {31'b0, bus.zero_o}, 32'd0);
    end

    // Reset during an SLL by 20; the result must not appear afterwards.
    bus.ALU_Operation_i = 4'b1100;
    bus.A_i = 32'h1;
    bus.B_i = 32'd20;
    bus.valid_i = 1'b1;
    @(posedge clk);
    #1 bus.valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midshift_rst_valid",  {31'b0, bus.valid_o}, 32'd0);
    check("midshift_rst_ready",  {31'b0, bus.ready_o}, 32'd1);
    check("midshift_rst_result", bus.result_o, 32'd0);
    bad = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.valid_o) bad++;
    end
    check("midshift_no_stale", 32'(bad), 32'd0);

    // Backpressure: the result is held while valid_i pulses are ignored.
    bus.ALU_Operation_i = 4'b1001;
    bus.A_i = 32'hF0;
    bus.B_i = 32'h0F;
    bus.valid_i = 1'b1;
    @(posedge clk);
    #1 bus.valid_i = 1'b0;
    @(negedge clk);
    check("bp_valid",  {31'b0, bus.valid_o}, 32'd1);
    check("bp_result", bus.result_o, 32'hFF);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      bus.valid_i = c[0];
      bus.ALU_Operation_i = 4'b0000;
      bus.A_i = 32'h1;
      bus.B_i = 32'h1;
      @(negedge clk);
      if (!bus.valid_o || bus.result_o !== 32'hFF || bus.ready_o) bad++;
    end
    check("bp_stall_stable", 32'(bad), 32'd0);
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    @(posedge clk);
    #1 bus.ready_i = 1'b0;
    @(negedge clk);
    check("bp_xfer_valid", {31'b0, bus.valid_o}, 32'd0);
    check("bp_xfer_ready", {31'b0, bus.ready_o}, 32'd1);
    repeat (3) @(negedge clk);
    check("bp_no_ghost", {31'b0, bus.valid_o}, 32'd0);

    // Random ops checked against the reference model.
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b1000, 4'b1001, 4'b1100};
    for (int n = 0; n < 150; n++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = (n % 10 == 9) ? 4'($urandom_range(0, 15)) : codes[$urandom_range(0, 7)];
      a  = $urandom;
      b  = (n % 7 == 3) ? 32'd0 : $urandom;
      do_op(op, a, b, res, z, lat);
      check($sformatf("rand%0d_op%0h_result", n, op), res, ref_result(op, a, b));
      check($sformatf("rand%0d_op%0h_zero", n, op), {31'b0, z},
            {31'b0, ref_result(op, a, b) == 32'd0});
      check($sformatf("rand%0d_op%0h_latency", n, op), 32'(lat), 32'(ref_latency(op, b)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
